// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB initiator and its wait timer.
package apb_pkg;

    // Transfer phases of the APB initiator
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    // Width of a counter that must hold 0..limit, never narrower than 1 bit
    function automatic int unsigned cnt_width(input int unsigned limit);
        if (limit < 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(limit + 32'd1);
        end
    endfunction

endpackage

// File: rtl/apb_master_fsm_if.sv
// Command/response port plus APB bus of the initiator, bundled together.
// The master modport is the initiator's view; slave is the environment's view.
interface apb_master_fsm_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_wait_timer.sv
// Counts stalled ACCESS cycles. expired_o flags the stalled cycle that brings
// the count up to TIMEOUT, so the FSM can abort on that same edge.
// The count saturates at TIMEOUT; TIMEOUT=0 disables expiry entirely.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int unsigned     CW    = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0]   LAST  = (TIMEOUT == 32'd0) ? {CW{1'b0}} : CW'(TIMEOUT - 32'd1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise count stalled cycles up to the limit
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CW{1'b0}};
        end else if (enable_i && (count_q != LIMIT)) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Wait-count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (TIMEOUT != 32'd0) && enable_i && (count_q >= LAST);

endmodule

// File: rtl/apb_master_fsm.sv
// APB initiator: one local command becomes one SETUP/ACCESS transfer and
// produces exactly one single-cycle response (data, slave error or timeout).
module apb_master_fsm
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_master_fsm_if.master  bus
);
    apb_state_e        state_q,     state_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              pwrite_q,    pwrite_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              timer_clear_s;
    logic              timer_en_s;
    logic              timer_expired_s;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (PCLK),
        .rst_n     (PRESETn),
        .clear_i   (timer_clear_s),
        .enable_i  (timer_en_s),
        .expired_o (timer_expired_s)
    );

    // Next state, bus phase outputs, command capture and response build-up
    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        psel_d        = 1'b0;
        penable_d     = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = rsp_err_q;
        rsp_rdata_d   = rsp_rdata_q;
        timer_clear_s = 1'b0;
        timer_en_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_d       = bus.cmd_addr;
                    pwdata_d      = bus.cmd_wdata;
                    pwrite_d      = bus.cmd_write;
                    psel_d        = 1'b1;
                    timer_clear_s = 1'b1;
                    state_d       = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    // Completion beats a simultaneous timeout
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.PSLVERR;
                    rsp_rdata_d = (!pwrite_q && !bus.PSLVERR) ? bus.PRDATA : {DATA_W{1'b0}};
                    state_d     = IDLE;
                end else begin
                    timer_en_s = 1'b1;
                    if (timer_expired_s) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = {DATA_W{1'b0}};
                        state_d     = IDLE;
                    end else begin
                        psel_d    = 1'b1;
                        penable_d = 1'b1;
                        state_d   = ACCESS;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the bus at once, no response
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            paddr_q     <= {ADDR_W{1'b0}};
            pwdata_q    <= {DATA_W{1'b0}};
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Ready only in IDLE and never while reset is asserted
    assign bus.cmd_ready = (state_q == IDLE) && PRESETn;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Directed plus randomized bench for apb_master_fsm with an APB register
// slave model and a transaction-level response model.
module tb_apb_master_fsm;
    localparam int unsigned TO = 4;

    logic PCLK;
    logic PRESETn;
    int   total;
    int   bad;
    logic [31:0] mem [8];

    apb_master_fsm_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_fsm #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One command through the bus. Starts and ends at a falling edge in IDLE
    // (or in the response cycle when b2b is set, so the next command is
    // offered during rsp_valid).
    task automatic do_cmd(input bit wr, input int idx, input logic [31:0] wd,
                          input int waits, input bit serr, input bit b2b);
        logic [31:0] addr;
        logic [31:0] exp_rd;
        bit          abort;
        bit          exp_err;
        addr  = 32'(idx) << 2;
        abort = 1'b0;
        check("ready_idle", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        @(negedge PCLK);
        // SETUP phase
        check("setup_psel", 64'(bus.PSEL), 64'd1);
        check("setup_penable", 64'(bus.PENABLE), 64'd0);
        check("setup_paddr", 64'(bus.PADDR), 64'(addr));
        check("setup_pwrite", 64'(bus.PWRITE), 64'(wr));
        check("setup_pwdata", 64'(bus.PWDATA), 64'(wd));
        check("setup_ready", 64'(bus.cmd_ready), 64'd0);
        check("setup_rsp", 64'(bus.rsp_valid), 64'd0);
        // junk that must be ignored outside IDLE / outside ACCESS
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_write = ~wr;
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
        bus.PREADY    = 1'($urandom_range(0, 1));
        bus.PSLVERR   = 1'($urandom_range(0, 1));
        bus.PRDATA    = $urandom;
        for (int k = 0; k <= waits; k++) begin
            @(negedge PCLK);
            check("acc_psel", 64'(bus.PSEL), 64'd1);
            check("acc_penable", 64'(bus.PENABLE), 64'd1);
            check("acc_paddr", 64'(bus.PADDR), 64'(addr));
            check("acc_pwrite", 64'(bus.PWRITE), 64'(wr));
            check("acc_pwdata", 64'(bus.PWDATA), 64'(wd));
            check("acc_rsp", 64'(bus.rsp_valid), 64'd0);
            check("acc_ready", 64'(bus.cmd_ready), 64'd0);
            if (k < waits) begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'($urandom_range(0, 1));
                bus.PRDATA  = $urandom;
                if (k + 1 == int'(TO)) begin
                    abort = 1'b1;
                    break;
                end
            end else begin
                bus.PREADY  = 1'b1;
                bus.PSLVERR = serr;
                bus.PRDATA  = wr ? $urandom : mem[idx];
            end
        end
        // Reference: abort -> error, else slave error; data only for clean reads
        exp_err = abort || serr;
        exp_rd  = (!wr && !exp_err) ? mem[idx] : 32'd0;
        if (wr && !exp_err) begin
            mem[idx] = wd;
        end
        @(negedge PCLK);
        check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
        check("rsp_psel", 64'(bus.PSEL), 64'd0);
        check("rsp_penable", 64'(bus.PENABLE), 64'd0);
        check("rsp_ready", 64'(bus.cmd_ready), 64'd1);
        check("idle_paddr_hold", 64'(bus.PADDR), 64'(addr));
        bus.cmd_valid = 1'b0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        if (!b2b) begin
            @(negedge PCLK);
            check("rsp_pulse", 64'(bus.rsp_valid), 64'd0);
            check("rsp_err_hold", 64'(bus.rsp_err), 64'(exp_err));
            check("rsp_rdata_hold", 64'(bus.rsp_rdata), 64'(exp_rd));
            check("idle_psel", 64'(bus.PSEL), 64'd0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 8; i++) mem[i] = 32'd0;
        PRESETn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'd0;
        bus.cmd_wdata = 32'd0;
        bus.PRDATA    = 32'd0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        #2;
        check("rst_psel", 64'(bus.PSEL), 64'd0);
        check("rst_penable", 64'(bus.PENABLE), 64'd0);
        check("rst_pwrite", 64'(bus.PWRITE), 64'd0);
        check("rst_paddr", 64'(bus.PADDR), 64'd0);
        check("rst_pwdata", 64'(bus.PWDATA), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("rst_ready", 64'(bus.cmd_ready), 64'd0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Directed: write, read-back, wait states, slave error, timeout
        do_cmd(1'b1, 1, 32'hDEADBEEF, 0, 1'b0, 1'b0);
        do_cmd(1'b0, 1, 32'h0, 0, 1'b0, 1'b0);
        do_cmd(1'b1, 2, 32'h12345678, 3, 1'b0, 1'b0);
        do_cmd(1'b0, 1, 32'h0, 0, 1'b1, 1'b0);
        do_cmd(1'b1, 3, 32'hCAFEF00D, 10, 1'b0, 1'b0);
        do_cmd(1'b0, 3, 32'h0, 0, 1'b0, 1'b0);
        // Last stalled cycle before the limit, then ready: completes cleanly
        do_cmd(1'b0, 2, 32'h0, int'(TO) - 1, 1'b0, 1'b0);
        // Exactly TIMEOUT stalls -> abort
        do_cmd(1'b0, 2, 32'h0, int'(TO), 1'b0, 1'b0);
        // Back-to-back: next command offered in the response cycle
        do_cmd(1'b1, 5, 32'hA5A5A5A5, 1, 1'b0, 1'b1);
        do_cmd(1'b0, 5, 32'h0, 0, 1'b0, 1'b0);

        // Randomized commands against the reference model
        for (int n = 0; n < 40; n++) begin
            do_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
                   int'($urandom_range(0, 6)), ($urandom_range(0, 7) == 0),
                   1'($urandom_range(0, 1)));
        end
        @(negedge PCLK);

        // Reset in the middle of a stalled ACCESS
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h0000001C;
        bus.cmd_wdata = 32'h55AA55AA;
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        bus.PREADY    = 1'b0;
        @(negedge PCLK);
        check("pre_rst_penable", 64'(bus.PENABLE), 64'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("mid_rst_psel", 64'(bus.PSEL), 64'd0);
        check("mid_rst_penable", 64'(bus.PENABLE), 64'd0);
        check("mid_rst_paddr", 64'(bus.PADDR), 64'd0);
        check("mid_rst_ready", 64'(bus.cmd_ready), 64'd0);
        check("mid_rst_rsp", 64'(bus.rsp_valid), 64'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        check("post_rst_ready", 64'(bus.cmd_ready), 64'd1);
        @(negedge PCLK);
        check("post_rst_rsp", 64'(bus.rsp_valid), 64'd0);
        check("post_rst_psel", 64'(bus.PSEL), 64'd0);
        do_cmd(1'b0, 1, 32'h0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
